// File: rtl/tnoc_local_port_arbiter.sv
// Packet-level round-robin arbiter sharing one router local input port among REQUESTERS sources.
// Define TNOC_LOCAL_ARBITER_ERROR_CHECK_EN to build the sticky protocol-error flag (o_error).
module tnoc_local_port_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int FLIT_WIDTH = 64,
    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS-1:0]            i_valid,
    output logic [REQUESTERS-1:0]            o_ready,
    input  logic [REQUESTERS*FLIT_WIDTH-1:0] i_flit,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [FLIT_WIDTH-1:0]            o_flit,
    output logic                             o_busy,
    output logic                             o_error,
    output logic                             o_dbg_state,
    output logic [PTR_W-1:0]                 o_dbg_ptr
);

    // Valid/ready: a flit moves on a rising edge where valid and ready are both high.
    // A source holding valid keeps valid and flit stable until that edge; ready may
    // depend combinationally on valid, never the reverse.

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  o_valid_q, o_valid_d;
    logic [FLIT_WIDTH-1:0] o_flit_q, o_flit_d;

    logic [REQUESTERS-1:0] head_vec;
    logic [REQUESTERS-1:0] tail_vec;
    logic [REQUESTERS-1:0] cand;
    logic [REQUESTERS-1:0] grant_vec;
    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      sel_idx;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  can_load;
    logic                  accept;

    for (genvar k = 0; k < REQUESTERS; k++) begin : g_flags
        assign head_vec[k] = i_flit[k*FLIT_WIDTH + FLIT_WIDTH - 1];
        assign tail_vec[k] = i_flit[k*FLIT_WIDTH + FLIT_WIDTH - 2];
    end

    assign cand     = i_valid & head_vec;
    assign can_load = !o_valid_q || i_ready;

    // First head-flagged requester at or after ptr in wrap order.
    always_comb begin
        logic [PTR_W-1:0] scan_idx;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int off = 0; off < REQUESTERS; off++) begin
            scan_idx = PTR_W'((int'(ptr_q) + off) % REQUESTERS);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign sel_idx = (state_q == ST_IDLE) ? win_idx : owner_q;

    always_comb begin
        sel_flit = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (PTR_W'(k) == sel_idx) begin
                sel_flit = i_flit[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (can_load) begin
            if (state_q == ST_IDLE) begin
                if (win_found) begin
                    grant_vec[win_idx] = 1'b1;
                end
            end else if (i_valid[owner_q]) begin
                grant_vec[owner_q] = 1'b1;
            end
        end
    end

    assign accept = |grant_vec;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        o_valid_d = o_valid_q;
        o_flit_d  = o_flit_q;
        if (accept) begin
            o_valid_d = 1'b1;
            o_flit_d  = sel_flit;
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
        if (accept) begin
            if (state_q == ST_IDLE) begin
                ptr_d = (win_idx == PTR_W'(REQUESTERS - 1)) ? '0 : win_idx + PTR_W'(1);
                // A head+tail flit is a whole packet, so no lock is taken.
                if (!sel_flit[FLIT_WIDTH-2]) begin
                    state_d = ST_LOCKED;
                    owner_d = win_idx;
                end
            end else if (sel_flit[FLIT_WIDTH-2]) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            o_valid_q <= 1'b0;
            o_flit_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
            o_flit_q  <= o_flit_d;
        end
    end

`ifdef TNOC_LOCAL_ARBITER_ERROR_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if ((state_q == ST_IDLE) && ((i_valid & ~head_vec) != '0)) begin
            error_d = 1'b1;
        end
        if ((state_q == ST_LOCKED) && accept && sel_flit[FLIT_WIDTH-1]) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    assign o_ready     = grant_vec;
    assign o_valid     = o_valid_q;
    assign o_flit      = o_flit_q;
    assign o_busy      = (state_q == ST_LOCKED);
    assign o_dbg_state = state_q;
    assign o_dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_tnoc_local_port_arbiter.sv
// Bench for tnoc_local_port_arbiter: constant vector table, hand-written corner sequences,
// then randomized traffic against a packet-level reference model and an output scoreboard.
module tb_tnoc_local_port_arbiter;
    localparam int R  = 4;
    localparam int FW = 16;
    localparam int PW = 2;
    localparam int NV = 22;
    localparam int N_RND = 2000;
`ifdef TNOC_LOCAL_ARBITER_ERROR_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [R-1:0]      i_valid;
    logic [R-1:0]      o_ready;
    logic [R*FW-1:0]   i_flit;
    logic              o_valid;
    logic              i_ready;
    logic [FW-1:0]     o_flit;
    logic              o_busy;
    logic              o_error;
    logic              o_dbg_state;
    logic [PW-1:0]     o_dbg_ptr;

    int checks = 0;
    int failures = 0;

    tnoc_local_port_arbiter #(.REQUESTERS(R), .FLIT_WIDTH(FW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit),
        .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit),
        .o_busy(o_busy), .o_error(o_error),
        .o_dbg_state(o_dbg_state), .o_dbg_ptr(o_dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        i_valid = '0;
        i_ready = 1'b1;
        i_flit = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Table flit layout: {head, tail, 6'b0, source[3:0], tag[3:0]}
    task automatic drive(input logic [R-1:0] v, input logic [R-1:0] h, input logic [R-1:0] t,
                         input logic [3:0] tag, input logic rdy);
        for (int k = 0; k < R; k++) begin
            i_flit[k*FW +: FW] = {h[k], t[k], 6'd0, 4'(k), tag};
        end
        i_valid = v;
        i_ready = rdy;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [R-1:0]  valid;
        logic [R-1:0]  head;
        logic [R-1:0]  tail;
        logic [3:0]    tag;
        logic          rdy;
        logic [R-1:0]  exp_ready;
        logic          exp_ov;
        logic          exp_busy;
        logic [3:0]    exp_src;
        logic [3:0]    exp_tag;
        logic [PW-1:0] exp_ptr;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk_vec(input logic [R-1:0] v, input logic [R-1:0] h, input logic [R-1:0] t,
                                    input logic [3:0] tag, input logic rdy, input logic [R-1:0] er,
                                    input logic ov, input logic bs, input logic [3:0] src,
                                    input logic [3:0] etag, input logic [PW-1:0] ptr);
        vec_t r;
        r.valid = v; r.head = h; r.tail = t; r.tag = tag; r.rdy = rdy;
        r.exp_ready = er; r.exp_ov = ov; r.exp_busy = bs;
        r.exp_src = src; r.exp_tag = etag; r.exp_ptr = ptr;
        return r;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    bit            m_locked;
    int            m_owner;
    int            m_ptr;
    bit            m_ov;
    bit            m_err;
    logic [FW-1:0] exp_q[$];
    logic [R-1:0]  seen_ready;

    function automatic logic [R-1:0] model_grant();
        logic [R-1:0] g;
        int k;
        g = '0;
        if (m_ov && !i_ready) return g;
        if (m_locked) begin
            if (i_valid[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int off = 0; off < R; off++) begin
            k = (m_ptr + off) % R;
            if (i_valid[k] && i_flit[k*FW + FW - 1]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic rnd_cycle();
        logic [R-1:0]  g;
        logic [FW-1:0] f;
        logic [FW-1:0] got;
        int k;
        bit bad_idle;
        #1;
        g = model_grant();
        seen_ready = o_ready;
        check("rnd o_ready", 64'(o_ready), 64'(g));
        if (m_ov && i_ready) begin
            got = o_flit;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rnd drain: got flit %0h expected empty queue", got);
            end else begin
                check("rnd drained flit", 64'(got), 64'(exp_q.pop_front()));
            end
        end
        bad_idle = 1'b0;
        for (int j = 0; j < R; j++) begin
            if (i_valid[j] && !i_flit[j*FW + FW - 1]) bad_idle = 1'b1;
        end
        if (!m_locked && bad_idle) m_err = m_err | EXP_ERR;
        if (g != '0) begin
            k = 0;
            for (int j = 0; j < R; j++) if (g[j]) k = j;
            f = i_flit[k*FW +: FW];
            if (m_locked) begin
                if (f[FW-1]) m_err = m_err | EXP_ERR;
                if (f[FW-2]) m_locked = 1'b0;
            end else begin
                m_ptr = (k + 1) % R;
                if (!f[FW-2]) begin
                    m_locked = 1'b1;
                    m_owner = k;
                end
            end
            m_ov = 1'b1;
            exp_q.push_back(f);
        end else if (i_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rnd o_valid", 64'(o_valid), 64'(m_ov));
        check("rnd o_busy", 64'(o_busy), 64'(m_locked));
        check("rnd o_error", 64'(o_error), 64'(m_err));
        check("rnd ptr", 64'(o_dbg_ptr), 64'(m_ptr));
        if (m_ov && exp_q.size() > 0) check("rnd stage flit", 64'(o_flit), 64'(exp_q[0]));
        @(negedge clk);
    endtask

    // ---------------- random traffic generator state ----------------
    logic [FW-1:0] cur[R];
    bit            pres[R];
    int            left[R];
    int            seq[R];

    initial begin
        bit h, t;
        rst = 1'b1;
        i_valid = '0;
        i_ready = 1'b0;
        i_flit = '0;
        seen_ready = '0;

        // Reset state
        do_reset();
        #1;
        check("reset o_ready", 64'(o_ready), 64'h0);
        check("reset o_valid", 64'(o_valid), 64'h0);
        check("reset o_flit", 64'(o_flit), 64'h0);
        check("reset o_busy", 64'(o_busy), 64'h0);
        check("reset o_error", 64'(o_error), 64'h0);
        check("reset ptr", 64'(o_dbg_ptr), 64'h0);
        check("reset state", 64'(o_dbg_state), 64'h0);
        @(negedge clk);

        // Round robin of single-flit packets, packet lock, backpressure, wrap and skip
        vecs[0]  = mk_vec(4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 1'b0, 4'd0, 4'h0, 2'd1);
        vecs[1]  = mk_vec(4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 4'b0010, 1'b1, 1'b0, 4'd1, 4'h1, 2'd2);
        vecs[2]  = mk_vec(4'hF, 4'hF, 4'hF, 4'h2, 1'b1, 4'b0100, 1'b1, 1'b0, 4'd2, 4'h2, 2'd3);
        vecs[3]  = mk_vec(4'hF, 4'hF, 4'hF, 4'h3, 1'b1, 4'b1000, 1'b1, 1'b0, 4'd3, 4'h3, 2'd0);
        vecs[4]  = mk_vec(4'hF, 4'hF, 4'hF, 4'h4, 1'b1, 4'b0001, 1'b1, 1'b0, 4'd0, 4'h4, 2'd1);
        vecs[5]  = mk_vec(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 2'd1);
        vecs[6]  = mk_vec(4'h5, 4'h5, 4'h1, 4'h6, 1'b1, 4'b0100, 1'b1, 1'b1, 4'd2, 4'h6, 2'd3);
        vecs[7]  = mk_vec(4'h5, 4'h1, 4'h1, 4'h7, 1'b1, 4'b0100, 1'b1, 1'b1, 4'd2, 4'h7, 2'd3);
        vecs[8]  = mk_vec(4'h5, 4'h1, 4'h5, 4'h8, 1'b1, 4'b0100, 1'b1, 1'b0, 4'd2, 4'h8, 2'd3);
        vecs[9]  = mk_vec(4'h1, 4'h1, 4'h1, 4'h9, 1'b1, 4'b0001, 1'b1, 1'b0, 4'd0, 4'h9, 2'd1);
        vecs[10] = mk_vec(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 2'd1);
        vecs[11] = mk_vec(4'h2, 4'h2, 4'h0, 4'hA, 1'b1, 4'b0010, 1'b1, 1'b1, 4'd1, 4'hA, 2'd2);
        vecs[12] = mk_vec(4'h2, 4'h0, 4'h0, 4'hB, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd1, 4'hA, 2'd2);
        vecs[13] = mk_vec(4'h2, 4'h0, 4'h0, 4'hB, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd1, 4'hA, 2'd2);
        vecs[14] = mk_vec(4'h2, 4'h0, 4'h0, 4'hB, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd1, 4'hA, 2'd2);
        vecs[15] = mk_vec(4'h2, 4'h0, 4'h0, 4'hB, 1'b1, 4'b0010, 1'b1, 1'b1, 4'd1, 4'hB, 2'd2);
        vecs[16] = mk_vec(4'h2, 4'h0, 4'h2, 4'hC, 1'b1, 4'b0010, 1'b1, 1'b0, 4'd1, 4'hC, 2'd2);
        vecs[17] = mk_vec(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 2'd2);
        vecs[18] = mk_vec(4'h4, 4'h4, 4'h4, 4'hD, 1'b1, 4'b0100, 1'b1, 1'b0, 4'd2, 4'hD, 2'd3);
        vecs[19] = mk_vec(4'h2, 4'h2, 4'h2, 4'hE, 1'b1, 4'b0010, 1'b1, 1'b0, 4'd1, 4'hE, 2'd2);
        vecs[20] = mk_vec(4'hA, 4'hA, 4'hA, 4'hF, 1'b1, 4'b1000, 1'b1, 1'b0, 4'd3, 4'hF, 2'd0);
        vecs[21] = mk_vec(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 2'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].head, vecs[i].tail, vecs[i].tag, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d o_ready", i), 64'(o_ready), 64'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d o_valid", i), 64'(o_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d o_busy", i), 64'(o_busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d ptr", i), 64'(o_dbg_ptr), 64'(vecs[i].exp_ptr));
            check($sformatf("vec%0d o_error", i), 64'(o_error), 64'h0);
            if (vecs[i].exp_ov) begin
                check($sformatf("vec%0d o_flit", i), 64'(o_flit[7:0]), 64'({vecs[i].exp_src, vecs[i].exp_tag}));
            end
            @(negedge clk);
        end

        // Reset in the middle of a packet
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0000, 4'h1, 1'b1);
        #1 check("rstmid head o_ready", 64'(o_ready), 64'b0001);
        @(posedge clk);
        #1;
        drive(4'b0001, 4'b0000, 4'b0000, 4'h2, 1'b1);
        #1 check("rstmid body o_ready", 64'(o_ready), 64'b0001);
        @(posedge clk);
        #1;
        check("rstmid busy before rst", 64'(o_busy), 64'h1);
        check("rstmid body on output", 64'(o_flit[7:0]), 64'h02);
        rst = 1'b1;
        #1;
        check("rstmid o_valid", 64'(o_valid), 64'h0);
        check("rstmid o_busy", 64'(o_busy), 64'h0);
        check("rstmid o_flit", 64'(o_flit), 64'h0);
        check("rstmid ptr", 64'(o_dbg_ptr), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1100, 4'b1100, 4'b1100, 4'h3, 1'b1);
        #1 check("rstmid next grant", 64'(o_ready), 64'b0100);
        @(posedge clk);
        #1;
        check("rstmid next o_valid", 64'(o_valid), 64'h1);
        check("rstmid next o_flit", 64'(o_flit[7:0]), 64'h23);
        @(negedge clk);

        // Headless flit in IDLE
        do_reset();
        drive(4'b0010, 4'b0000, 4'b0000, 4'h5, 1'b1);
        #1 check("err body-only o_ready", 64'(o_ready), 64'h0);
        @(posedge clk);
        #1 check("err flag set", 64'(o_error), 64'(EXP_ERR));
        check("err no output", 64'(o_valid), 64'h0);
        @(negedge clk);
        i_valid = '0;
        repeat (3) @(negedge clk);
        check("err flag sticky", 64'(o_error), 64'(EXP_ERR));
        do_reset();
        #1 check("err cleared by rst", 64'(o_error), 64'h0);

        // Head flag inside a locked packet is still forwarded
        @(negedge clk);
        drive(4'b0001, 4'b0001, 4'b0000, 4'h6, 1'b1);
        #1 check("lockhead first o_ready", 64'(o_ready), 64'b0001);
        @(posedge clk);
        #1;
        drive(4'b0001, 4'b0001, 4'b0000, 4'h7, 1'b1);
        #1 check("lockhead second o_ready", 64'(o_ready), 64'b0001);
        @(posedge clk);
        #1;
        check("lockhead o_error", 64'(o_error), 64'(EXP_ERR));
        check("lockhead o_flit", 64'(o_flit[7:0]), 64'h07);
        check("lockhead o_busy", 64'(o_busy), 64'h1);
        drive(4'b0001, 4'b0000, 4'b0001, 4'h8, 1'b1);
        #1 check("lockhead tail o_ready", 64'(o_ready), 64'b0001);
        @(posedge clk);
        #1 check("lockhead released", 64'(o_busy), 64'h0);
        @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        m_locked = 1'b0;
        m_owner = 0;
        m_ptr = 0;
        m_ov = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
        seen_ready = '0;
        for (int k = 0; k < R; k++) begin
            cur[k] = '0;
            pres[k] = 1'b0;
            left[k] = 0;
            seq[k] = 0;
        end
        for (int c = 0; c < N_RND; c++) begin
            for (int k = 0; k < R; k++) begin
                if (pres[k] && seen_ready[k]) pres[k] = 1'b0;
                if (!pres[k] && ($urandom_range(0, 3) != 0)) begin
                    h = 1'b0;
                    if (left[k] == 0) begin
                        left[k] = $urandom_range(1, 4);
                        h = 1'b1;
                    end
                    left[k] = left[k] - 1;
                    t = (left[k] == 0);
                    cur[k] = {h, t, 2'(k), 12'(seq[k])};
                    seq[k] = seq[k] + 1;
                    pres[k] = 1'b1;
                end
                i_valid[k] = pres[k];
                i_flit[k*FW +: FW] = cur[k];
            end
            i_ready = ($urandom_range(0, 3) != 0);
            rnd_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tnoc_local_port_arbiter.md
# tnoc_local_port_arbiter

Packet-level round-robin arbiter that shares one router local input port among several requesters at a mesh node, for example a master and a slave bridge. It sits between the requesters and the `flit_in_if` local port of the fabric. A grant is held from a head flit through the matching tail flit, so packets are never interleaved. Output is one registered pipeline stage.

## Interface
- `REQUESTERS`, default 4: number of requesters; 2..8.
- `FLIT_WIDTH`, default 64: flit width, minimum 2.
  - Bit `FLIT_WIDTH-1` is the head flag.
  - Bit `FLIT_WIDTH-2` is the tail flag.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  `REQUESTERS`  per-requester flit valid.
- `o_ready`  out  `REQUESTERS`  per-requester flit accept.
- `i_flit`  in  `REQUESTERS*FLIT_WIDTH`  packed flits; requester k occupies bits `[k*FLIT_WIDTH +: FLIT_WIDTH]`.
- `o_valid`  out  1  valid toward the router local port.
- `i_ready`  in  1  ready from the router local port.
- `o_flit`  out  `FLIT_WIDTH`  flit toward the router.
- `o_busy`  out  1  high while in LOCKED.
- `o_error`  out  1  sticky protocol-error flag.

## Operation
- The FSM has two states, IDLE and LOCKED. It also keeps an owner index and a round-robin pointer `ptr`. Both are `$clog2(REQUESTERS)` bits wide, with a minimum of 1 bit.
- Stage register "can load" = `!o_valid || i_ready`.
- **IDLE**
  - Candidates are requesters with `i_valid` high and the head flag set.
  - The winner is the first candidate found scanning `ptr, ptr+1, …`, wrapping modulo `REQUESTERS`.
  - When the stage can load, only the winner sees `o_ready`; the flit loads into the stage register and `ptr` becomes winner+1, wrapping modulo `REQUESTERS`.
  - If the winning flit also has the tail flag set (single-flit packet), the FSM stays in IDLE.
  - Otherwise the FSM goes to LOCKED with owner = winner.
- **LOCKED**
  - Only the owner gets `o_ready`, and only when the stage can load.
  - When a flit with the tail flag is accepted, the FSM returns to IDLE.
  - Other requesters see `o_ready` = 0. Their `i_valid` and flit must stay stable.
- Non-candidates are never granted:
  - In IDLE, a valid requester whose flit lacks the head flag gets no `o_ready` and is ignored.
  - In LOCKED, an owner flit carrying a head flag is still forwarded.
- `o_ready` is combinational from `i_valid`, `i_flit` flags, state, `ptr`, `o_valid` and `i_ready`. It is one-hot or zero.
- Stage register behaviour:
  - `o_valid` clears when `i_ready` is high and nothing loads.
  - `o_flit` holds its value while `o_valid && !i_ready`.

## Timing
- Reset values: state IDLE, `ptr` 0, owner 0, `o_valid` 0, `o_flit` 0, `o_ready` 0, `o_busy` 0, `o_error` 0.
- Latency: a flit accepted at edge N is presented on `o_flit` with `o_valid` after edge N, i.e. one cycle.
- Throughput is one flit per cycle under continuous `i_ready`.
- Back-to-back packets:
  - A tail accepted at edge N returns the FSM to IDLE, and a head from any requester can be accepted at edge N+1. There is no idle bubble, because arbitration in IDLE is same-cycle.
  - If the owner itself requests again, it wins only when no requester at `ptr` or later in wrap order is requesting.
- Backpressure: while `o_valid && !i_ready`, all `o_ready` are 0 and the state holds.
- `rst` asserted mid-packet:
  - Immediate return to reset values.
  - The partial packet already forwarded is not completed.
  - The flit in the stage register is discarded.
- `ptr` wraps from `REQUESTERS-1` to 0.

## Configuration
- `TNOC_LOCAL_ARBITER_ERROR_CHECK_EN` defined:
  - `o_error` sets one cycle after either protocol violation:
    - in IDLE, a valid requester presents a flit without the head flag;
    - in LOCKED, an accepted owner flit carries a head flag.
  - It stays set until `rst`.
- Macro undefined: `o_error` is tied to 0 and the checking logic is removed.
- Arbitration behaviour is identical in both builds.

## Test plan
- **Single-flit packets from all requesters:** `REQUESTERS`=4, all four assert a head+tail flit every cycle with `i_ready`=1.
  - Required: grants 0,1,2,3,0,… in order.
  - `o_valid` stays continuously high from cycle 2.
- **Packet lock:** requester 2 sends head, body, tail while requester 0 is also valid.
  - Required: `o_flit` shows all three flits of requester 2 consecutively.
  - Requester 0 is granted on the cycle after the tail is accepted.
  - `o_busy` is high for exactly the two cycles after the head is accepted.
- **Backpressure:** hold `i_ready`=0 for 3 cycles in mid-packet.
  - Required: `o_flit` is stable, all `o_ready` are 0, and no flit is lost or duplicated.
  - The packet completes after `i_ready` rises.
- **Wrap and skip:** `ptr`=3 with only requester 1 valid.
  - Required: requester 1 is granted and `ptr` becomes 2.
  - Next, requesters 1 and 3 are both valid: requester 3 wins.
- **Reset mid-packet:** assert `rst` after the body flit of a 3-flit packet.
  - Required: `o_valid` is 0 immediately.
  - Next, a different requester's head is granted on the first cycle after `rst` deasserts.
- **Error check (macro defined):** requester 1 is valid in IDLE with a body-only flit.
  - Required: `o_ready[1]`=0 and `o_error`=1 on the next cycle, remaining 1 until `rst`.
  - With the macro undefined, `o_error` stays 0.
